if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the CPU core's decode/execute.
- Owns the fetch PC and issues word fetches to instruction memory over a request/grant/response handshake.
- Buffers returned {pc, inst} pairs in a small queue and presents them to decode with a valid/ready handshake.
- Supports redirect (branch/jump target from execute); flushes the queue and drops a stale in-flight response.

---
 rtl/if_fetch_unit_pkg.sv | 18 +
 rtl/if_queue.sv | 59 +++++
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 tb/tb_if_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM states, queue entry layout, constants.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_REQ     = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IF_NOP      = 32'h0000_0013;

endpackage

// File: rtl/if_queue.sv
// Small synchronous FIFO of {pc, inst} pairs between fetch and decode.
// Flush wins over push/pop; pop on empty and push on full are ignored.
module if_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  if_entry_t     push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output if_entry_t     head_o
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  if_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   wr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_pop;
  logic            do_push;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL_C) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request,
// credit-limited queue toward decode, redirect with stale-response drop.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        if_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;
  localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic [CW-1:0] count;
  if_entry_t     head;
  if_entry_t     push_data;
  logic          push;
  logic          pop;
  logic          flush;
  logic          q_valid;
  logic          outstanding;
  logic [UW-1:0] used;
  logic          credit_ok;
  logic          granted;

  assign q_valid     = (count != '0);
  assign outstanding = (state_q != IF_REQ);
  assign used        = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign credit_ok   = (used < DEPTH_U);

  assign imem_req  = !reset && (state_q == IF_REQ) && credit_ok;
  assign imem_addr = reset ? RESET_PC : fetch_pc_q;
  assign granted   = imem_req && imem_gnt;

  assign pop       = q_valid && if_ready && !redirect;
  assign push_data = '{pc: req_pc_q, inst: imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc & ~32'h3;
      // a request still in flight after this edge must be thrown away
      if (granted || (outstanding && !imem_rvalid)) begin
        state_d = IF_DISCARD;
      end else begin
        state_d = IF_REQ;
      end
    end else begin
      unique case (state_q)
        IF_REQ: begin
          if (granted) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = IF_REQ;
          end
        end
        IF_DISCARD: begin
          if (imem_rvalid) begin
            state_d = IF_REQ;
          end
        end
        default: state_d = IF_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IF_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  if_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (count),
    .head_o      (head)
  );

  assign if_valid = !reset && q_valid;
  assign if_pc    = reset ? 32'h0 : head.pc;
  assign if_inst  = reset ? 32'h0 : head.inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a small imem model.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready = 1'b0;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_ready    (if_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sb_t         exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  logic        rst_v = 1'b1;
  logic        rdy_v = 1'b0;
  logic        gnt_v = 1'b1;
  logic        redir_v = 1'b0;
  logic [31:0] rpc_v = '0;
  int          lat = 1;
  bit          data_mode = 1'b0;

  bit          pend_v = 1'b0;
  int          pend_w = 0;
  logic [31:0] pend_d = '0;
  int          grant_cnt = 0;
  int          cyc = 0;
  int          first_req = -1;
  int          first_vld = -1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkdata(input logic [31:0] a);
    return data_mode ? (a ^ 32'h5A5A_0013) : 32'h0000_0013;
  endfunction

  task automatic step();
    sb_t         e;
    logic        rv;
    logic [31:0] a;
    @(negedge clk);
    cyc++;
    rv = 1'b0;
    if (pend_v) begin
      if (pend_w == 0) begin
        rv     = 1'b1;
        pend_v = 1'b0;
      end else begin
        pend_w--;
      end
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? pend_d : 32'hDEAD_BEEF;
    imem_gnt    = gnt_v;
    reset       = rst_v;
    redirect    = redir_v;
    redirect_pc = rpc_v;
    if_ready    = rdy_v;
    #1;
    if (rst_v) begin
      exp_q.delete();
    end else begin
      if (imem_req && first_req < 0) first_req = cyc;
      if (if_valid && first_vld < 0) first_vld = cyc;
      if (if_valid && rdy_v && !redir_v) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_inst", if_inst, e.inst);
        end
        pop_log.push_back(if_pc);
      end
      if (redir_v) exp_q.delete();
      if (imem_req && gnt_v) begin
        if (pend_v) chk("one_out", 32'(pend_v), 32'd0);
        a = imem_addr;
        grant_cnt++;
        req_log.push_back(a);
        pend_v = 1'b1;
        pend_w = lat - 1;
        pend_d = mkdata(a);
        if (!redir_v) exp_q.push_back('{pc: a, inst: mkdata(a)});
      end
    end
  endtask

  task automatic do_reset(input bit keep_pend);
    rst_v = 1'b1;
    redir_v = 1'b0;
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_vld", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    if (!keep_pend) pend_v = 1'b0;
    rst_v = 1'b0;
    req_log.delete();
    pop_log.delete();
    grant_cnt = 0;
    first_req = -1;
    first_vld = -1;
  endtask

  task automatic run_grants(input int n);
    repeat (60) if (grant_cnt < n) step();
    chk("grant_to", 32'(grant_cnt), 32'(n));
  endtask

  task automatic run_pops(input int n);
    repeat (60) if (pop_log.size() < n) step();
    chk("pop_to", 32'(pop_log.size()), 32'(n));
  endtask

  initial begin
    // zero-wait memory, latency and address sequence
    do_reset(1'b0);
    lat = 1; rdy_v = 1'b1; gnt_v = 1'b1; data_mode = 1'b0;
    run_grants(3);
    chk("addr0", req_log[0], 32'h0);
    chk("addr1", req_log[1], 32'h4);
    chk("addr2", req_log[2], 32'h8);
    chk("latency", 32'(first_vld - first_req), 32'd2);
    chk("first_pc", pop_log[0], 32'h0);

    // decode stalled: credit limits fetch to DEPTH entries
    do_reset(1'b0);
    rdy_v = 1'b0; data_mode = 1'b1;
    repeat (10) step();
    chk("stall_grants", 32'(grant_cnt), 32'd2);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_vld", 32'(if_valid), 32'd1);
    rdy_v = 1'b1;
    run_grants(3);
    chk("resume_addr", req_log[2], 32'h8);

    // grant withheld: request and address hold steady
    do_reset(1'b0);
    gnt_v = 1'b0;
    repeat (3) begin
      step();
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, 32'h0);
    end
    chk("hold_cnt", 32'(grant_cnt), 32'd0);
    gnt_v = 1'b1;
    step();
    chk("gnt_cnt", 32'(grant_cnt), 32'd1);
    chk("gnt_addr", req_log[0], 32'h0);

    // redirect while waiting on a slow response
    do_reset(1'b0);
    lat = 3; rdy_v = 1'b0;
    run_grants(2);
    redir_v = 1'b1; rpc_v = 32'h0000_0103;
    step();
    redir_v = 1'b0;
    step();
    chk("flush_vld", 32'(if_valid), 32'd0);
    rdy_v = 1'b1;
    run_grants(3);
    chk("redir_addr", req_log[2], 32'h0000_0100);
    run_pops(1);
    chk("redir_pc", pop_log[0], 32'h0000_0100);

    // redirect coinciding with the response
    do_reset(1'b0);
    lat = 1; rdy_v = 1'b1;
    run_grants(1);
    chk("rv_due", 32'(pend_v && pend_w == 0), 32'd1);
    redir_v = 1'b1; rpc_v = 32'h0000_0200;
    step();
    redir_v = 1'b0;
    run_grants(2);
    chk("rv_redir_addr", req_log[1], 32'h0000_0200);
    run_pops(1);
    chk("rv_redir_pc", pop_log[0], 32'h0000_0200);

    // PC wrap, then reset while a response is in flight
    do_reset(1'b0);
    gnt_v = 1'b0; redir_v = 1'b1; rpc_v = 32'hFFFF_FFFC;
    step();
    redir_v = 1'b0; gnt_v = 1'b1;
    run_grants(2);
    chk("wrap_a", req_log[0], 32'hFFFF_FFFC);
    chk("wrap_b", req_log[1], 32'h0);
    run_pops(2);
    chk("wrap_pc", pop_log[0], 32'hFFFF_FFFC);
    lat = 6;
    run_grants(grant_cnt + 1);
    step();
    do_reset(1'b1);
    gnt_v = 1'b0; lat = 1;
    repeat (10) if (pend_v) step();
    chk("late_rsp", 32'(pend_v), 32'd0);
    step();
    chk("late_vld", 32'(if_valid), 32'd0);
    gnt_v = 1'b1;
    run_pops(1);
    chk("post_rst_pc", pop_log[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
